// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared state encoding, tag prefix and width helper for the UART TX arbiter
package uart_arb_pkg;
  typedef enum logic [1:0] {S_IDLE, S_TAG, S_START, S_WAIT} state_e;
  localparam logic [7:0] TAG_PREFIX = 8'hF0;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: round-robin priority pick starting at ptr_i and wrapping
module uart_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  // Scan from farthest to nearest so the last hit is the closest to the pointer
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[(int'(ptr_i) + k) % N]) begin
        gnt_o = '0;
        gnt_o[(int'(ptr_i) + k) % N] = 1'b1;
        idx_o = IW'((int'(ptr_i) + k) % N);
        any_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among NUM_REQ producers
// UART_TX_ARB_TAG_EN: precede each payload frame with a TAG_PREFIX|grant_id frame
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 4096,
  localparam int IW         = idx_w(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      tx_busy,
  input  logic                      tx_done,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  output logic [IW-1:0]             grant_id,
  output logic                      active,
  output logic                      timeout_err
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  state_e              state_q;
  logic [NUM_REQ-1:0]  gnt;
  logic [IW-1:0]       idx, ptr_q, grant_q;
  logic                any;
  logic [DATA_W-1:0]   data_q, req_byte;
  logic [CW-1:0]       cnt_q;
  logic                err_q;
`ifdef UART_TX_ARB_TAG_EN
  logic [DATA_W-1:0]   pay_q;
  logic                tag_q;
`endif
  uart_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req_i(req_valid), .ptr_i(ptr_q), .gnt_o(gnt), .idx_o(idx), .any_o(any)
  );
  assign req_byte    = req_data[idx*DATA_W +: DATA_W];
  assign req_ready   = (state_q == S_IDLE) ? gnt : '0;
  assign tx_start    = (state_q == S_START || state_q == S_TAG) && !tx_busy;
  assign active      = state_q != S_IDLE;
  assign tx_data     = data_q;
  assign grant_id    = grant_q;
  assign timeout_err = err_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef UART_TX_ARB_TAG_EN
      pay_q   <= '0;
      tag_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: if (any) begin
          grant_q <= idx;
          ptr_q   <= (idx == IW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
`ifdef UART_TX_ARB_TAG_EN
          data_q  <= DATA_W'(TAG_PREFIX) | DATA_W'(idx);
          pay_q   <= req_byte;
          tag_q   <= 1'b1;
          state_q <= S_TAG;
`else
          data_q  <= req_byte;
          state_q <= S_START;
`endif
        end
        S_TAG, S_START: if (!tx_busy) begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        // A timeout abandons whatever is pending, including a payload behind a tag
        S_WAIT: if (tx_done) begin
`ifdef UART_TX_ARB_TAG_EN
          tag_q   <= 1'b0;
          data_q  <= tag_q ? pay_q : data_q;
          state_q <= tag_q ? S_START : S_IDLE;
`else
          state_q <= S_IDLE;
`endif
        end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          err_q   <= 1'b1;
          state_q <= S_IDLE;
        end else begin
          cnt_q   <= cnt_q + 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scoreboard bench for uart_tx_arbiter (honours UART_TX_ARB_TAG_EN)
module tb_uart_tx_arbiter;
  localparam int FRAME = 4;
`ifdef UART_TX_ARB_TAG_EN
  localparam int NFR = 2;
`else
  localparam int NFR = 1;
`endif
  logic        clk = 1'b0, rst = 1'b1;
  logic [3:0]  req_valid = '0, req_ready;
  logic [31:0] req_data = '0;
  logic        tx_busy, tx_done = 1'b0, tx_start;
  logic [7:0]  tx_data;
  logic [1:0]  grant_id;
  logic        active, timeout_err;
  logic        busy_m = 1'b0, force_busy = 1'b0, mute = 1'b0, pend = 1'b0;
  int          fcnt = 0, checks = 0, errors = 0, starts = 0, grants = 0;
  logic [7:0]  sb[$];

  assign tx_busy = busy_m | force_busy;
  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_busy(tx_busy), .tx_done(tx_done),
    .tx_start(tx_start), .tx_data(tx_data), .grant_id(grant_id),
    .active(active), .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_grant(input int id, input logic [7:0] b);
`ifdef UART_TX_ARB_TAG_EN
    sb.push_back(8'hF0 | 8'(id));
`endif
    sb.push_back(b);
  endtask

  task automatic push_first(input int id, input logic [7:0] b);
`ifdef UART_TX_ARB_TAG_EN
    sb.push_back(8'hF0 | 8'(id));
`else
    sb.push_back(b);
`endif
  endtask

  task automatic wait_idle(input string tag);
    int c = 0;
    do begin @(posedge clk); #1; c++; end while (active && c < 300);
    chk(tag, {31'b0, active}, 0);
  endtask

  // Transmitter model: a start sampled mid-cycle becomes a FRAME-long busy then a done pulse
  always @(negedge clk) if (tx_start && !mute) pend = 1'b1;
  always @(posedge clk) begin
    #1;
    tx_done = 1'b0;
    if (pend) begin
      pend = 1'b0; fcnt = FRAME; busy_m = 1'b1;
    end else if (fcnt > 0) begin
      fcnt--;
      if (fcnt == 0) begin busy_m = 1'b0; tx_done = 1'b1; end
    end
  end

  always @(negedge clk) begin
    if (tx_start) begin
      starts++;
      if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
      else chk("tx_data", {24'b0, tx_data}, {24'b0, sb.pop_front()});
    end
    if (req_ready != 0) begin
      grants++;
      chk("ready_onehot", {31'b0, $onehot(req_ready)}, 1);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=hang expected=finish");
    $fatal(1);
  end

  initial begin
    int s0, g0, c;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_active", {31'b0, active}, 0);
    chk("rst_start", {31'b0, tx_start}, 0);
    chk("rst_data", {24'b0, tx_data}, 0);
    chk("rst_grant", {30'b0, grant_id}, 0);
    chk("rst_err", {31'b0, timeout_err}, 0);
    chk("rst_ready", {28'b0, req_ready}, 0);
    rst = 1'b0;
    // single requester
    @(posedge clk); #1;
    req_valid = 4'b0001; req_data[7:0] = 8'h55; push_grant(0, 8'h55);
    #1 chk("t1_ready", {28'b0, req_ready}, 4'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    #1 chk("t1_start_n1", {31'b0, tx_start}, 1);
    wait_idle("t1_idle");
    // all four valid, strict rotation from pointer 0
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'hA0 + 8'(i);
    for (int i = 0; i < 5; i++) push_grant(i % 4, 8'hA0 + 8'(i % 4));
    g0 = grants; req_valid = 4'b1111;
    c = 0;
    while (grants < g0 + 5 && c < 2000) begin @(posedge clk); #1; c++; end
    req_valid = '0;
    chk("t2_grants", grants - g0, 5);
    wait_idle("t2_idle");
    chk("t2_last_id", {30'b0, grant_id}, 0);
    // transmitter busy holds off the start pulse
    force_busy = 1'b1; req_data[15:8] = 8'h77; req_valid = 4'b0010; push_grant(1, 8'h77);
    #1 chk("t3_ready", {28'b0, req_ready}, 4'b0010);
    @(posedge clk); #1; req_valid = '0; s0 = starts;
    repeat (5) @(posedge clk);
    #1 chk("t3_held", starts - s0, 0);
    force_busy = 1'b0;
    wait_idle("t3_idle");
    chk("t3_pulses", starts - s0, NFR);
    // timeout with a silent transmitter
    mute = 1'b1; req_data[23:16] = 8'h99; req_valid = 4'b0100; push_first(2, 8'h99);
    #1 chk("t4_ready", {28'b0, req_ready}, 4'b0100);
    @(posedge clk); #1; req_valid = '0;
    c = 0;
    do begin @(negedge clk); c++; end while (!tx_start && c < 50);
    chk("t4_start_seen", {31'b0, tx_start}, 1);
    repeat (16) @(negedge clk);
    chk("t4_err_early", {31'b0, timeout_err}, 0);
    chk("t4_active", {31'b0, active}, 1);
    @(negedge clk);
    chk("t4_err_set", {31'b0, timeout_err}, 1);
    chk("t4_idle", {31'b0, active}, 0);
    mute = 1'b0;
    @(posedge clk); #1;
    req_data[31:24] = 8'h42; req_valid = 4'b1000; push_grant(3, 8'h42);
    #1 chk("t4_next_ready", {28'b0, req_ready}, 4'b1000);
    @(posedge clk); #1; req_valid = '0;
    wait_idle("t4_next_idle");
    chk("t4_sticky", {31'b0, timeout_err}, 1);
    // reset mid-frame with pointer at 2
    req_data[15:8] = 8'h11; req_valid = 4'b0010; push_first(1, 8'h11);
    @(posedge clk); #1; req_valid = '0;
    c = 0;
    do begin @(negedge clk); c++; end while (!tx_start && c < 50);
    @(posedge clk); #1;
    chk("t5_in_wait", {31'b0, active}, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5_active", {31'b0, active}, 0);
    chk("t5_start", {31'b0, tx_start}, 0);
    chk("t5_data", {24'b0, tx_data}, 0);
    chk("t5_grant", {30'b0, grant_id}, 0);
    chk("t5_err", {31'b0, timeout_err}, 0);
    req_data[15:8] = 8'h21; req_data[31:24] = 8'h23; req_valid = 4'b1010; push_grant(1, 8'h21);
    #1 chk("t5_ready", {28'b0, req_ready}, 4'b0010);
    @(posedge clk); #1; req_valid = '0;
    wait_idle("t5_idle");
    chk("t5_grant_id", {30'b0, grant_id}, 1);
    // requester 2 with 0x3C (tag then payload when tagging is built in)
    req_data[23:16] = 8'h3C; req_valid = 4'b0100; push_grant(2, 8'h3C); s0 = starts;
    #1 chk("t6_ready", {28'b0, req_ready}, 4'b0100);
    @(posedge clk); #1; req_valid = '0;
    wait_idle("t6_idle");
    chk("t6_pulses", starts - s0, NFR);
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
